// File: rtl/pipe_fetch_pkg.sv
// rtl/pipe_fetch_pkg.sv - shared RV32I fetch constants and fetch state encodings
package pipe_fetch_pkg;

  localparam int INST_W = 32;
  localparam int XLEN   = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_ISSUE = 2'd0,
    FS_WAIT  = 2'd1,
    FS_KILL  = 2'd2
  } fetch_state_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/pipe_fetch_fifo.sv
// rtl/pipe_fetch_fifo.sv - {pc,inst} queue with flush and registered head outputs
module fetch_fifo
  import pipe_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [INST_W-1:0] push_inst,
  input  logic [XLEN-1:0]   push_pc,
  input  logic              pop,
  input  logic              flush,
  output logic [PTR_W:0]    count,
  output logic              head_valid,
  output logic [INST_W-1:0] head_inst,
  output logic [XLEN-1:0]   head_pc
);

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0]   pc_mem   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [PTR_W:0]    count_n, remain;
  logic              do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count != '0) && !flush;
    do_push  = push && !flush;
    remain   = count - (PTR_W+1)'(do_pop);
    rd_ptr_n = rd_ptr + PTR_W'(do_pop);
    wr_ptr_n = wr_ptr + PTR_W'(do_push);
    count_n  = remain + (PTR_W+1)'(do_push);
    if (flush) begin
      rd_ptr_n = '0;
      wr_ptr_n = '0;
      count_n  = '0;
    end
  end

  // Head registers load from next-cycle state, bypassing the array when the
  // pushed word lands straight at the head of an otherwise empty queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_inst  <= '0;
      head_pc    <= '0;
    end else begin
      rd_ptr     <= rd_ptr_n;
      wr_ptr     <= wr_ptr_n;
      count      <= count_n;
      head_valid <= (count_n != '0);
      if (!flush) begin
        if (do_push && remain == '0) begin
          head_inst <= push_inst;
          head_pc   <= push_pc;
        end else if (remain != '0) begin
          head_inst <= inst_mem[rd_ptr_n];
          head_pc   <= pc_mem[rd_ptr_n];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      inst_mem[wr_ptr] <= push_inst;
      pc_mem[wr_ptr]   <= push_pc;
    end
  end

endmodule

// File: rtl/pipe_fetch.sv
// rtl/pipe_fetch.sv - RV32I instruction fetch: PC, memory request FSM, redirect handling
module pipe_fetch
  import pipe_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  input  logic        mem_rack,
  input  logic [31:0] mem_rdata,
  input  logic        redir_e,
  input  logic [31:0] redir_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [PTR_W:0]  count, room_cnt;
  logic            push, pop;

  assign pop  = out_valid && out_ready && !redir_e;
  assign push = (state == FS_WAIT) && mem_rack && !redir_e;
  // Only one read is ever outstanding, so a slot is free for it when the
  // occupancy left after this cycle's pop is below the depth.
  assign room_cnt = count - (PTR_W+1)'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FS_ISSUE;
      pc       <= RESET_PC;
      mem_re   <= 1'b0;
      mem_addr <= RESET_PC;
    end else if (redir_e) begin
      pc <= align_word(redir_pc);
      case (state)
        FS_WAIT, FS_KILL: begin
          if (mem_rack) begin
            mem_re <= 1'b0;
            state  <= FS_ISSUE;
          end else begin
            state  <= FS_KILL;
          end
        end
        default: state <= FS_ISSUE;
      endcase
    end else begin
      case (state)
        FS_ISSUE: begin
          if (room_cnt < DEPTH_C) begin
            mem_re   <= 1'b1;
            mem_addr <= pc;
            state    <= FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (mem_rack) begin
            pc     <= mem_addr + 32'd4;
            mem_re <= 1'b0;
            state  <= FS_ISSUE;
          end
        end
        FS_KILL: begin
          if (mem_rack) begin
            mem_re <= 1'b0;
            state  <= FS_ISSUE;
          end
        end
        default: begin
          mem_re <= 1'b0;
          state  <= FS_ISSUE;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_inst  (mem_rdata),
    .push_pc    (mem_addr),
    .pop        (pop),
    .flush      (redir_e),
    .count      (count),
    .head_valid (out_valid),
    .head_inst  (out_inst),
    .head_pc    (out_pc)
  );

endmodule
